fadd_share_arb: RTL and testbench

Shares one AXI-stream floating-point adder IP between N_REQ requesters using round-robin arbitration. Operations are issued back-to-back, so several can be outstanding inside the IP at once. An in-order tag FIFO records which requester owns each issued operation, and each result is routed back to that owner. It sits between the core's FP execution requesters and the single adder IP instance.

---
 rtl/fadd_arb_pkg.sv | 30 +++
 rtl/fadd_tag_fifo.sv | 57 +++++
 rtl/fadd_share_arb.sv | 120 ++++++++++++
 tb/tb_fadd_share_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_arb_pkg.sv
// Shared types and the round-robin pick helper for the shared FP adder arbiter.
package fadd_arb_pkg;

    typedef logic [31:0] fp32_t;

    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int unsigned        n);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !r.found && valid[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fadd_tag_fifo.sv
// In-order owner-tag FIFO; push and pop may coincide, including when full.
module fadd_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/fadd_share_arb.sv
// Round-robin sharing of one AXI-stream FP adder IP among N_REQ requesters,
// with an in-order tag FIFO routing each result back to its issuer.
module fadd_share_arb
    import fadd_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*32-1:0]       req_a,
    input  logic [N_REQ*32-1:0]       req_b,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [31:0]               rsp_data,
    output logic [31:0]               fadd_axis_a_tdata,
    output logic                      fadd_axis_a_tvalid,
    input  logic                      fadd_axis_a_tready,
    output logic [31:0]               fadd_axis_b_tdata,
    output logic                      fadd_axis_b_tvalid,
    input  logic                      fadd_axis_b_tready,
    input  logic [31:0]               fadd_axis_result_tdata,
    input  logic                      fadd_axis_result_tvalid,
    output logic                      fadd_axis_result_tready,
    output logic [$clog2(DEPTH):0]    outstanding
);

    localparam int unsigned TAG_W = $clog2(N_REQ);

    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   winner;
    logic [TAG_W-1:0]   tag_out;
    fp32_t              a_data;
    fp32_t              b_data;
    logic               a_pend;
    logic               b_pend;
    logic               slot_free;
    logic               grant;
    logic               fifo_full;
    logic               fifo_empty;
    logic               res_hs;
    pick_t              pick;
    logic [MAX_REQ-1:0] valid_ext;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = req_valid;
        pick                   = rr_pick(valid_ext, 3'(rr_ptr), N_REQ);
        winner                 = pick.idx[TAG_W-1:0];
        // The slot can reload in the same cycle its last pending channel handshakes.
        slot_free              = (!a_pend || fadd_axis_a_tready) &&
                                 (!b_pend || fadd_axis_b_tready);
        // Qualified by rstn so req_ready reads 0 for the whole reset window.
        grant                  = rstn && slot_free && !fifo_full && pick.found;
        req_ready              = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_data <= '0;
            b_data <= '0;
            a_pend <= 1'b0;
            b_pend <= 1'b0;
            rr_ptr <= '0;
        end else if (grant) begin
            a_data <= req_a[32*winner +: 32];
            b_data <= req_b[32*winner +: 32];
            a_pend <= 1'b1;
            b_pend <= 1'b1;
            rr_ptr <= (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end else begin
            if (a_pend && fadd_axis_a_tready) begin
                a_pend <= 1'b0;
            end
            if (b_pend && fadd_axis_b_tready) begin
                b_pend <= 1'b0;
            end
        end
    end

    assign fadd_axis_a_tdata       = a_data;
    assign fadd_axis_a_tvalid      = a_pend;
    assign fadd_axis_b_tdata       = b_data;
    assign fadd_axis_b_tvalid      = b_pend;
    assign fadd_axis_result_tready = !fifo_empty;
    assign res_hs                  = fadd_axis_result_tvalid && !fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (res_hs) begin
                rsp_valid[tag_out] <= 1'b1;
                rsp_data           <= fadd_axis_result_tdata;
            end
        end
    end

    fadd_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant),
        .pop   (res_hs),
        .din   (winner),
        .dout  (tag_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_fadd_share_arb.sv
// Scoreboard bench for fadd_share_arb with a queue-based adder IP model.
module tb_fadd_share_arb;
    import fadd_arb_pkg::*;

    localparam int N   = 4;
    localparam int D   = 8;
    localparam int LAT = 5;

    typedef struct packed { logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct packed { int idx; logic [31:0] data; } exp_t;
    typedef struct packed { int cyc; int idx; logic [31:0] data; } log_t;
    typedef struct packed { logic [31:0] data; int due; } res_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic [31:0]     a_tdata, b_tdata;
    logic            a_tvalid, b_tvalid;
    logic            a_tready = 1'b0, b_tready = 1'b0;
    logic [31:0]     r_tdata = '0;
    logic            r_tvalid = 1'b0;
    logic            r_tready;
    logic [3:0]      outstanding;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit a_block = 0, b_block = 0, rand_bp = 0, stray = 0;
    int allowed = 1 << 30;

    op_t  pend_q[N][$];
    exp_t sb[$];
    log_t grant_log[$];
    log_t rsp_log[$];

    fadd_share_arb #(.N_REQ(N), .DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .fadd_axis_a_tdata(a_tdata), .fadd_axis_a_tvalid(a_tvalid), .fadd_axis_a_tready(a_tready),
        .fadd_axis_b_tdata(b_tdata), .fadd_axis_b_tvalid(b_tvalid), .fadd_axis_b_tready(b_tready),
        .fadd_axis_result_tdata(r_tdata), .fadd_axis_result_tvalid(r_tvalid),
        .fadd_axis_result_tready(r_tready),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Stand-in for the adder IP: exact for the directed 1.0 + 2.0 case, a fixed mixing function otherwise.
    function automatic logic [31:0] fake_fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic add_op(input int i, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        pend_q[i].push_back(o);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_rsp_data"}, rsp_data, 0);
        chk({nm, "_axis_valids"}, {a_tvalid, b_tvalid, r_tready}, 0);
        chk({nm, "_axis_data"}, {a_tdata, b_tdata}, 0);
        chk({nm, "_outstanding"}, outstanding, 0);
    endtask

    task automatic wait_grants(input int n, input int bound, input string nm);
        int k = 0;
        while (grant_log.size() < n && k < bound) begin tick(); k++; end
        chk({nm, "_grant_wait"}, grant_log.size() >= n, 1);
    endtask

    task automatic wait_rsps(input int n, input int bound, input string nm);
        int k = 0;
        while (rsp_log.size() < n && k < bound) begin tick(); k++; end
        chk({nm, "_rsp_wait"}, rsp_log.size() >= n, 1);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int  k = 0;
        bit  busy = 1;
        while (busy && k < bound) begin
            busy = (outstanding != 0) || (sb.size() != 0) || a_tvalid || b_tvalid;
            for (int i = 0; i < N; i++) if (pend_q[i].size() != 0) busy = 1;
            if (busy) begin tick(); k++; end
        end
        chk({nm, "_drain"}, busy, 0);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    // Requester side: observe grants, check the round-robin rule, record expectations.
    always begin : driver
        logic [N-1:0] acc;
        int           mptr;
        int           w, ew, j;
        exp_t         e;
        log_t         g;
        @(negedge clk);
        acc = '0;
        if (!rstn) begin
            for (int i = 0; i < N; i++) pend_q[i].delete();
            grant_log.delete();
            mptr = 0;
        end else if (req_ready != 0) begin
            acc = req_ready;
            w = -1;
            ew = -1;
            for (int i = N - 1; i >= 0; i--) if (acc[i]) w = i;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (ew < 0 && req_valid[j]) ew = j;
            end
            chk("grant_onehot", $countones(acc), 1);
            chk("grant_winner", w, ew);
            if (pend_q[w].size() > 0) begin
                e.idx  = w;
                e.data = fake_fadd(pend_q[w][0].a, pend_q[w][0].b);
                sb.push_back(e);
            end
            g.cyc = cyc; g.idx = w; g.data = '0;
            grant_log.push_back(g);
            mptr = (w + 1) % N;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
            req_valid[i] = (pend_q[i].size() > 0);
            req_a[32*i +: 32] = (pend_q[i].size() > 0) ? pend_q[i][0].a : 32'h0;
            req_b[32*i +: 32] = (pend_q[i].size() > 0) ? pend_q[i][0].b : 32'h0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        log_t r;
        if (!rstn) begin
            sb.delete();
            rsp_log.delete();
        end else if (rsp_valid != 0) begin
            chk("rsp_onehot", $countones(rsp_valid), 1);
            r.cyc = cyc; r.idx = -1; r.data = rsp_data;
            for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) r.idx = i;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", rsp_valid, 64'(1) << e.idx);
                chk("rsp_data", rsp_data, e.data);
            end
            rsp_log.push_back(r);
        end
    end

    // Adder IP model: pairs operands in arrival order, returns results LAT cycles later.
    always begin : ip_model
        logic [31:0] qa[$], qb[$];
        res_t        rq[$];
        res_t        nr;
        int          given;
        bit          pa_v, pa_hs, pb_v, pb_hs;
        logic [31:0] pa_d, pb_d;
        @(negedge clk);
        if (!rstn) begin
            qa.delete(); qb.delete(); rq.delete();
            given = 0; pa_v = 0; pb_v = 0; pa_hs = 0; pb_hs = 0;
        end else begin
            if (pa_v && !pa_hs) begin
                chk("a_tvalid_hold", a_tvalid, 1);
                chk("a_tdata_hold", a_tdata, pa_d);
            end
            if (pb_v && !pb_hs) begin
                chk("b_tvalid_hold", b_tvalid, 1);
                chk("b_tdata_hold", b_tdata, pb_d);
            end
            pa_v = a_tvalid; pa_hs = a_tvalid && a_tready; pa_d = a_tdata;
            pb_v = b_tvalid; pb_hs = b_tvalid && b_tready; pb_d = b_tdata;
            if (pa_hs) qa.push_back(a_tdata);
            if (pb_hs) qb.push_back(b_tdata);
            if (r_tvalid && r_tready && rq.size() > 0) begin
                void'(rq.pop_front());
                given++;
            end
            if (qa.size() > 0 && qb.size() > 0) begin
                nr.data = fake_fadd(qa.pop_front(), qb.pop_front());
                nr.due  = cyc + LAT;
                rq.push_back(nr);
            end
        end
        @(posedge clk);
        #1;
        a_tready = !a_block && (!rand_bp || $urandom_range(0, 3) != 0);
        b_tready = !b_block && (!rand_bp || $urandom_range(0, 3) != 0);
        if (rq.size() > 0 && rq[0].due <= cyc && given < allowed &&
            (!rand_bp || $urandom_range(0, 2) != 0)) begin
            r_tvalid = 1'b1;
            r_tdata  = rq[0].data;
        end else if (stray) begin
            r_tvalid = 1'b1;
            r_tdata  = 32'hDEAD_BEEF;
        end else begin
            r_tvalid = 1'b0;
            r_tdata  = '0;
        end
    end

    initial begin : main
        int k;
        logic [31:0] ob;

        // Reset state
        tick();
        check_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        // Single op on requester 2
        add_op(2, 32'h3F80_0000, 32'h4000_0000);
        wait_grants(1, 20, "single");
        chk("single_ready", req_ready, 4'b0100);
        chk("single_idx", grant_log[0].idx, 2);
        tick();
        chk("single_ready_drop", req_ready, 0);
        chk("single_tvalids", {a_tvalid, b_tvalid}, 2'b11);
        chk("single_tdata", {a_tdata, b_tdata}, {32'h3F80_0000, 32'h4000_0000});
        wait_rsps(1, 40, "single");
        chk("single_rsp_valid", rsp_valid, 4'b0100);
        chk("single_rsp_data", rsp_data, 32'h4040_0000);
        tick();
        chk("single_rsp_pulse", rsp_valid, 0);
        chk("single_outstanding", outstanding, 0);

        // Contention: all four requesters, two ops each
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add_op(i, $urandom, $urandom);
        wait_grants(8, 40, "cont");
        for (int g = 0; g < 8 && g < grant_log.size(); g++) begin
            chk($sformatf("cont_order_%0d", g), grant_log[g].idx, g % N);
            chk($sformatf("cont_cycle_%0d", g), grant_log[g].cyc - grant_log[0].cyc, g);
        end
        wait_rsps(8, 60, "cont");
        for (int g = 0; g < 8 && g < rsp_log.size(); g++)
            chk($sformatf("cont_rsp_order_%0d", g), rsp_log[g].idx, g % N);
        wait_idle(100, "cont");

        // Split backpressure: B channel stalled three cycles
        do_reset();
        b_block = 1;
        ob = 32'h4120_0000;
        add_op(0, 32'h4110_0000, ob);
        add_op(1, 32'h4130_0000, 32'h4140_0000);
        wait_grants(1, 20, "split");
        chk("split_first", grant_log[0].idx, 0);
        tick();
        chk("split_c1_valids", {a_tvalid, b_tvalid}, 2'b11);
        chk("split_c1_bdata", b_tdata, ob);
        tick();
        chk("split_c2_valids", {a_tvalid, b_tvalid}, 2'b01);
        chk("split_c2_bdata", b_tdata, ob);
        chk("split_c2_ready", req_ready, 0);
        tick();
        chk("split_c3_valids", {a_tvalid, b_tvalid}, 2'b01);
        chk("split_c3_ready", req_ready, 0);
        b_block = 0;
        tick();
        chk("split_c4_bvalid", b_tvalid, 1);
        chk("split_c4_bdata", b_tdata, ob);
        chk("split_c4_grant", req_ready, 4'b0010);
        wait_idle(100, "split");

        // FIFO full: results withheld while requester 1 streams
        do_reset();
        allowed = 0;
        for (int i = 0; i < 10; i++) add_op(1, $urandom, $urandom);
        repeat (20) tick();
        chk("full_accepts", grant_log.size(), 8);
        chk("full_outstanding", outstanding, 8);
        chk("full_no_ready", req_ready, 0);
        allowed = 1;
        k = 0;
        while (!(r_tvalid && r_tready) && k < 10) begin tick(); k++; end
        chk("full_release_seen", r_tvalid && r_tready, 1);
        tick();
        chk("full_rsp", rsp_valid, 4'b0010);
        chk("full_regrant", req_ready, 4'b0010);
        tick();
        chk("full_again_ready", req_ready, 0);
        chk("full_again_outstanding", outstanding, 8);
        allowed = 1 << 30;
        wait_idle(200, "full");
        chk("full_total_grants", grant_log.size(), 10);

        // Stray result with empty FIFO
        do_reset();
        stray = 1;
        repeat (3) begin
            tick();
            chk("stray_tready", r_tready, 0);
            chk("stray_rsp", rsp_valid, 0);
            chk("stray_outstanding", outstanding, 0);
        end
        stray = 0;

        // Reset with three ops in flight
        do_reset();
        allowed = 0;
        add_op(0, $urandom, $urandom);
        add_op(1, $urandom, $urandom);
        add_op(2, $urandom, $urandom);
        k = 0;
        while (outstanding != 3 && k < 20) begin tick(); k++; end
        chk("midrst_outstanding", outstanding, 3);
        chk("midrst_a_tvalid", a_tvalid, 1);
        rstn = 1'b0;
        #1;
        check_zero("midrst");
        tick();
        tick();
        rstn = 1'b1;
        allowed = 1 << 30;
        tick();
        add_op(3, 32'h3F80_0000, 32'h4000_0000);
        wait_rsps(1, 40, "midrst");
        if (rsp_log.size() > 0) begin
            chk("midrst_owner", rsp_log[0].idx, 3);
            chk("midrst_data", rsp_log[0].data, 32'h4040_0000);
        end
        wait_idle(100, "midrst");

        // Randomized traffic with random backpressure on every channel
        do_reset();
        rand_bp = 1;
        for (int i = 0; i < 60; i++) begin
            add_op($urandom_range(0, N - 1), $urandom, $urandom);
            if ($urandom_range(0, 1) != 0) tick();
        end
        wait_idle(3000, "rand");
        rand_bp = 0;
        chk("rand_grants", grant_log.size(), 60);
        chk("rand_rsps", rsp_log.size(), 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
